// File: rtl/uart_tx.sv
// UART transmitter with CTS flow control: byte in on valid/ready, async serial frame out; line lags state by one cycle.
// Backpressure: o_ready only in IDLE, so the source holds i_valid for the whole frame; CTS gates frame start only.
module uart_tx #(
    parameter int ClksPerBit = 868,
    parameter int DataBits   = 8,
    parameter int ParityEn   = 0,
    parameter int ParityOdd  = 0,
    parameter int StopBits   = 1,
    parameter int CtsEn      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DataBits-1:0] i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_busy,
    output logic                o_uart_tx,
    input  logic                i_uart_cts_n
);

    localparam int BAUD_W = $clog2(ClksPerBit);
    localparam int BIT_W  = $clog2(DataBits + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(ClksPerBit - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DataBits - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(StopBits - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CTS,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DataBits-1:0]   shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic [1:0]            cts_sync_q, cts_sync_d;

    logic cts_s;
    logic cts_ok;
    logic cell_done;
    logic accept;

    assign cts_s     = cts_sync_q[1];
    assign cts_ok    = (CtsEn == 0) | ~cts_s;
    assign cell_done = (baud_q == BAUD_LAST);

    assign o_ready   = (state_q == IDLE) & ~i_rst;
    assign o_busy    = (state_q != IDLE);
    assign o_uart_tx = tx_q;
    assign accept    = i_valid & o_ready;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tx_d       = 1'b1;
        cts_sync_d = {cts_sync_q[0], i_uart_cts_n};

        // Baud counter free-runs through every bit cell and wraps on the boundary.
        if (state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP) begin
            baud_d = cell_done ? '0 : baud_q + BAUD_W'(1);
        end else begin
            baud_d = '0;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    shreg_d = i_data;
                    par_d   = (^i_data) ^ (ParityOdd != 0);
                    state_d = cts_ok ? START : WAIT_CTS;
                end
            end
            WAIT_CTS: begin
                tx_d = 1'b1;
                if (cts_ok) begin
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (cell_done) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                tx_d = shreg_q[0];
                if (cell_done) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = (ParityEn != 0) ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                tx_d = par_q;
                if (cell_done) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                // Bit counter doubles as the stop-cell counter.
                if (cell_done) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            cts_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            cts_sync_q <= cts_sync_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit: three instances cover 8N1, 8E2 and 8O1 framing.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic [2:0] vld;
    logic       cts_n;
    logic [2:0] rdy_w;
    logic [2:0] busy_w;
    logic [2:0] tx_w;

    int n_assert;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx #(.ClksPerBit(4), .DataBits(8), .ParityEn(0), .ParityOdd(0), .StopBits(1), .CtsEn(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(vld[0]), .o_ready(rdy_w[0]),
        .o_busy(busy_w[0]), .o_uart_tx(tx_w[0]), .i_uart_cts_n(cts_n)
    );

    uart_tx #(.ClksPerBit(4), .DataBits(8), .ParityEn(1), .ParityOdd(0), .StopBits(2), .CtsEn(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(vld[1]), .o_ready(rdy_w[1]),
        .o_busy(busy_w[1]), .o_uart_tx(tx_w[1]), .i_uart_cts_n(cts_n)
    );

    uart_tx #(.ClksPerBit(4), .DataBits(8), .ParityEn(1), .ParityOdd(1), .StopBits(1), .CtsEn(1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(vld[2]), .o_ready(rdy_w[2]),
        .o_busy(busy_w[2]), .o_uart_tx(tx_w[2]), .i_uart_cts_n(cts_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a byte and wait (bounded) for the accept edge; returns just after it.
    task automatic send(input int idx, input logic [7:0] b, input bit hold, input string tag);
        int w;
        data     = b;
        vld[idx] = 1'b1;
        w        = 0;
        while (rdy_w[idx] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, 32'(rdy_w[idx]), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) vld[idx] = 1'b0;
    endtask

    // frm[0] is the start bit, then each later cell in line order; every cell is checked on all 4 cycles.
    task automatic check_frame(input int idx, input logic [11:0] frm, input int n, input logic [7:0] b,
                               input string tag, output int waited);
        logic [7:0] dec;
        dec    = '0;
        waited = 0;
        while (tx_w[idx] !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_start_seen"}, 32'(tx_w[idx]), 32'd0);
        chk({tag, "_busy"}, 32'(busy_w[idx]), 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s_cell%0d_cyc%0d", tag, i, k), 32'(tx_w[idx]), 32'(frm[i]));
                if (k == 2 && i >= 1 && i <= 8) dec[i-1] = tx_w[idx];
                @(negedge clk);
            end
        end
        chk({tag, "_decode"}, 32'(dec), 32'(b));
    endtask

    int w;
    int c;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        vld      = 3'b001;
        data     = 8'hAA;
        cts_n    = 1'b0;

        // Reset held 3 cycles with i_valid high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx_w[0]), 32'd1);
            chk("rst_ready", 32'(rdy_w[0]), 32'd0);
            chk("rst_busy", 32'(busy_w[0]), 32'd0);
        end
        rst = 1'b0;
        vld = 3'b000;
        #1;
        chk("rel_ready", 32'(rdy_w[0]), 32'd1);
        repeat (3) @(negedge clk);

        // Single byte 0xA5, line 0 | 1,0,1,0,0,1,0,1 | 1.
        send(0, 8'hA5, 1'b0, "a5");
        check_frame(0, 12'b00_1_10100101_0, 10, 8'hA5, "a5", w);
        chk("a5_ready_after", 32'(rdy_w[0]), 32'd1);
        chk("a5_busy_after", 32'(busy_w[0]), 32'd0);

        // Flow control: CTS deasserted holds the frame in WAIT_CTS.
        @(negedge clk);
        cts_n = 1'b1;
        repeat (3) @(negedge clk);
        send(0, 8'h3C, 1'b0, "fc");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("fc_hold_tx", 32'(tx_w[0]), 32'd1);
            chk("fc_hold_busy", 32'(busy_w[0]), 32'd1);
        end
        cts_n = 1'b0;
        c = 0;
        while (tx_w[0] !== 1'b0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("fc_start_delay", 32'(c >= 3 && c <= 4), 32'd1);
        fork
            begin
                repeat (16) @(negedge clk);
                cts_n = 1'b1;
            end
        join_none
        check_frame(0, 12'b00_1_00111100_0, 10, 8'h3C, "fc", w);
        chk("fc_ready_after", 32'(rdy_w[0]), 32'd1);

        cts_n = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back with i_valid held: one idle cycle between frames.
        send(0, 8'h00, 1'b1, "b2b0");
        data = 8'hFF;
        check_frame(0, 12'b00_1_00000000_0, 10, 8'h00, "b2b0", w);
        data = 8'h55;
        check_frame(0, 12'b00_1_11111111_0, 10, 8'hFF, "b2b1", w);
        vld[0] = 1'b0;
        chk("b2b1_gap", 32'(w), 32'd1);
        check_frame(0, 12'b00_1_01010101_0, 10, 8'h55, "b2b2", w);
        chk("b2b2_gap", 32'(w), 32'd1);
        repeat (2) @(negedge clk);
        chk("b2b_idle_tx", 32'(tx_w[0]), 32'd1);
        chk("b2b_idle_busy", 32'(busy_w[0]), 32'd0);

        // Even parity, two stop bits: 0x07 -> parity 1, stop high 8 cycles.
        send(1, 8'h07, 1'b0, "pe");
        check_frame(1, 12'b1_1_1_00000111_0, 12, 8'h07, "pe", w);
        chk("pe_ready_after", 32'(rdy_w[1]), 32'd1);

        // Odd parity: 0x07 -> parity 0.
        send(2, 8'h07, 1'b0, "po");
        check_frame(2, 12'b0_1_0_00000111_0, 11, 8'h07, "po", w);
        chk("po_ready_after", 32'(rdy_w[2]), 32'd1);

        // Reset during data bit 3 of 0xF0.
        send(0, 8'hF0, 1'b0, "mr");
        w = 0;
        while (tx_w[0] !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (18) @(negedge clk);
        chk("mr_bit3", 32'(tx_w[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_tx", 32'(tx_w[0]), 32'd1);
        chk("mr_busy", 32'(busy_w[0]), 32'd0);
        chk("mr_ready", 32'(rdy_w[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send(0, 8'h81, 1'b0, "ar");
        check_frame(0, 12'b00_1_10000001_0, 10, 8'h81, "ar", w);
        chk("ar_ready_after", 32'(rdy_w[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
